uart_echo_debug: RTL and testbench

UART loopback block for the debugger path: receives 8N1 serial frames on `i_rx` with 16× oversampling, and retransmits each received byte unchanged on `tx`. It also exposes a 4-bit debug code of the receiver and transmitter FSM states. It sits between the board's serial pins and the debug unit. It is used standalone to bring up and verify the serial link.

---
 rtl/uart_echo_debug.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_echo_debug.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_debug.sv
// UART echo block for the debugger serial path.
// Receives 8N1 frames with 16x oversampling and sends each received byte
// back out unchanged. A one-entry holding register sits between the
// receiver and the transmitter. If a second byte arrives before the first
// has been handed to the transmitter, the newer byte wins.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   i_rx   serial input, idle high, sampled directly
//   tx     serial output, idle high, registered
//   state  debug code {tx_state[1:0], rx_state[1:0]}
module uart_echo_debug #(
  parameter int unsigned BAUD_DIV = 163,
  parameter int unsigned DBIT     = 8,
  parameter int unsigned SB_TICK  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic       tx,
  output logic [3:0] state
);

  localparam int unsigned BaudW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [3:0]  SbLast = 4'(SB_TICK - 1);
  localparam logic [NW-1:0] NLast = NW'(DBIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_st_e;

  // Baud generator: one-cycle tick every BAUD_DIV clocks.
  logic [BaudW-1:0] baud_q;
  logic             tick;

  assign tick = (baud_q == BaudW'(BAUD_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)     baud_q <= '0;
    else if (tick) baud_q <= '0;
    else           baud_q <= baud_q + BaudW'(1);
  end

  // Receiver
  uart_st_e        rx_st_q, rx_st_d;
  logic [3:0]      rx_s_q, rx_s_d;
  logic [NW-1:0]   rx_n_q, rx_n_d;
  logic [DBIT-1:0] rx_b_q, rx_b_d;
  logic            rx_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_st_q <= StIdle;
      rx_s_q  <= '0;
      rx_n_q  <= '0;
      rx_b_q  <= '0;
    end else begin
      rx_st_q <= rx_st_d;
      rx_s_q  <= rx_s_d;
      rx_n_q  <= rx_n_d;
      rx_b_q  <= rx_b_d;
    end
  end

  always_comb begin
    rx_st_d = rx_st_q;
    rx_s_d  = rx_s_q;
    rx_n_d  = rx_n_q;
    rx_b_d  = rx_b_q;
    unique case (rx_st_q)
      StIdle: begin
        // Start detection does not wait for a tick.
        if (!i_rx) begin
          rx_st_d = StStart;
          rx_s_d  = '0;
        end
      end
      StStart: begin
        // Eight ticks lands on the middle of the start bit.
        if (tick) begin
          if (rx_s_q == 4'd7) begin
            rx_st_d = StData;
            rx_s_d  = '0;
            rx_n_d  = '0;
          end else begin
            rx_s_d = rx_s_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (rx_s_q == 4'd15) begin
            rx_s_d = '0;
            rx_b_d = {i_rx, rx_b_q[DBIT-1:1]};
            if (rx_n_q == NLast) rx_st_d = StStop;
            else                 rx_n_d  = rx_n_q + NW'(1);
          end else begin
            rx_s_d = rx_s_q + 4'd1;
          end
        end
      end
      StStop: begin
        // Stop-bit level is ignored; the byte is delivered regardless.
        if (tick) begin
          if (rx_s_q == SbLast) rx_st_d = StIdle;
          else                  rx_s_d  = rx_s_q + 4'd1;
        end
      end
      default: rx_st_d = StIdle;
    endcase
  end

  always_comb begin
    rx_done = (rx_st_q == StStop) && tick && (rx_s_q == SbLast);
  end

  // Echo glue: one-entry holding register.
  logic [DBIT-1:0] hold_q;
  logic            pending_q;
  logic            tx_start;
  uart_st_e        tx_st_q, tx_st_d;

  assign tx_start = pending_q && (tx_st_q == StIdle);

  // A byte captured in the same cycle the previous one is handed off stays pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q    <= '0;
      pending_q <= 1'b0;
    end else if (rx_done) begin
      hold_q    <= rx_b_q;
      pending_q <= 1'b1;
    end else if (tx_start) begin
      pending_q <= 1'b0;
    end
  end

  // Transmitter
  logic [3:0]      tx_s_q, tx_s_d;
  logic [NW-1:0]   tx_n_q, tx_n_d;
  logic [DBIT-1:0] tx_b_q, tx_b_d;
  logic            tx_q, tx_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st_q <= StIdle;
      tx_s_q  <= '0;
      tx_n_q  <= '0;
      tx_b_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      tx_st_q <= tx_st_d;
      tx_s_q  <= tx_s_d;
      tx_n_q  <= tx_n_d;
      tx_b_q  <= tx_b_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    tx_st_d = tx_st_q;
    tx_s_d  = tx_s_q;
    tx_n_d  = tx_n_q;
    tx_b_d  = tx_b_q;
    tx_d    = tx_q;
    unique case (tx_st_q)
      StIdle: begin
        tx_d = 1'b1;
        if (tx_start) begin
          tx_b_d  = hold_q;
          tx_s_d  = '0;
          tx_d    = 1'b0;
          tx_st_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          if (tx_s_q == 4'd15) begin
            tx_st_d = StData;
            tx_s_d  = '0;
            tx_n_d  = '0;
            tx_d    = tx_b_q[0];
          end else begin
            tx_s_d = tx_s_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (tx_s_q == 4'd15) begin
            tx_s_d = '0;
            tx_b_d = tx_b_q >> 1;
            if (tx_n_q == NLast) begin
              tx_st_d = StStop;
              tx_d    = 1'b1;
            end else begin
              tx_n_d = tx_n_q + NW'(1);
              tx_d   = tx_b_d[0];
            end
          end else begin
            tx_s_d = tx_s_q + 4'd1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (tx_s_q == SbLast) tx_st_d = StIdle;
          else                  tx_s_d  = tx_s_q + 4'd1;
        end
      end
      default: tx_st_d = StIdle;
    endcase
  end

  always_comb begin
    tx    = tx_q;
    state = {tx_st_q, rx_st_q};
  end

endmodule

// File: tb/tb_uart_echo_debug.sv
// Directed bench for uart_echo_debug with BAUD_DIV=1 (one tick per clock),
// so every bit lasts exactly 16 clocks and all timing is cycle-exact.
module tb_uart_echo_debug;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_rx;
  logic       tx;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Decoded echo frames {stop, data[7:0], start} and the cycle tx fell.
  logic [9:0] echo_q[$];
  int         fall_q[$];

  uart_echo_debug #(
    .BAUD_DIV(1),
    .DBIT    (8),
    .SB_TICK (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .i_rx (i_rx),
    .tx   (tx),
    .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bit k of the frame is seen by the DUT on edges 16k..16k+15 after the call.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    i_rx = 1'b0;
    step(16);
    for (int i = 0; i < 8; i++) begin
      i_rx = data[i];
      step(16);
    end
    i_rx = stop_bit;
    step(16);
    i_rx = 1'b1;
  endtask

  task automatic wait_echoes(input int n, input int budget);
    int k;
    k = 0;
    while (echo_q.size() < n && k < budget) begin
      step(1);
      k++;
    end
  endtask

  // tx line decoder: samples each bit at its middle.
  initial begin : mon
    logic       prev;
    logic [9:0] fr;
    int         fc;
    prev = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (prev === 1'b1 && tx === 1'b0) begin
        fc = cyc;
        step(8);
        fr[0] = tx;
        for (int i = 1; i < 10; i++) begin
          step(16);
          fr[i] = tx;
        end
        echo_q.push_back(fr);
        fall_q.push_back(fc);
      end
      prev = tx;
    end
  end

  task automatic test_reset;
    reset = 1'b1;
    i_rx  = 1'b1;
    step(2);
    checks++;
    if (tx !== 1'b1) begin
      failures++;
      $display("FAIL reset_tx: got %b expected 1", tx);
    end
    checks++;
    if (state !== 4'h0) begin
      failures++;
      $display("FAIL reset_state: got %h expected 0", state);
    end
    checks++;
    if (dut.rx_s_q !== 4'h0) begin
      failures++;
      $display("FAIL reset_rx_s: got %h expected 0", dut.rx_s_q);
    end
    reset = 1'b0;
    step(4);
  endtask

  task automatic test_single;
    int base;
    echo_q.delete();
    fall_q.delete();
    base = cyc;
    fork
      send_frame(8'h70, 1'b1);
      begin
        step(8);
        checks++;
        if (state[1:0] !== 2'd1) begin
          failures++;
          $display("FAIL single_start_hold: got %0d expected 1", state[1:0]);
        end
        step(1);
        checks++;
        if (state[1:0] !== 2'd2) begin
          failures++;
          $display("FAIL single_to_data: got %0d expected 2", state[1:0]);
        end
        step(127);
        checks++;
        if (state[1:0] !== 2'd2) begin
          failures++;
          $display("FAIL single_data_hold: got %0d expected 2", state[1:0]);
        end
        step(1);
        checks++;
        if (state[1:0] !== 2'd3) begin
          failures++;
          $display("FAIL single_to_stop: got %0d expected 3", state[1:0]);
        end
        step(15);
        checks++;
        if (state[1:0] !== 2'd3) begin
          failures++;
          $display("FAIL single_stop_hold: got %0d expected 3", state[1:0]);
        end
        step(1);
        checks++;
        if (state[1:0] !== 2'd0 || tx !== 1'b1) begin
          failures++;
          $display("FAIL single_to_idle: got rx=%0d tx=%b expected rx=0 tx=1",
                   state[1:0], tx);
        end
        step(1);
        checks++;
        if (tx !== 1'b0 || state[3:2] !== 2'd1) begin
          failures++;
          $display("FAIL single_tx_start: got tx=%b txst=%0d expected tx=0 txst=1",
                   tx, state[3:2]);
        end
      end
    join
    wait_echoes(1, 400);
    checks++;
    if (echo_q.size() != 1) begin
      failures++;
      $display("FAIL single_count: got %0d expected 1", echo_q.size());
    end
    checks++;
    if (echo_q[0] !== {1'b1, 8'h70, 1'b0}) begin
      failures++;
      $display("FAIL single_frame: got %h expected %h", echo_q[0], {1'b1, 8'h70, 1'b0});
    end
    checks++;
    if (fall_q[0] != base + 154) begin
      failures++;
      $display("FAIL single_latency: got %0d expected %0d", fall_q[0] - base, 154);
    end
    step(20);
  endtask

  task automatic test_patterns;
    logic [7:0] pats[5];
    pats = '{8'hAA, 8'hF0, 8'h0F, 8'h00, 8'hFF};
    echo_q.delete();
    fall_q.delete();
    for (int i = 0; i < 5; i++) begin
      send_frame(pats[i], 1'b1);
      step(16);
    end
    wait_echoes(5, 600);
    checks++;
    if (echo_q.size() != 5) begin
      failures++;
      $display("FAIL patterns_count: got %0d expected 5", echo_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (echo_q[i] !== {1'b1, pats[i], 1'b0}) begin
        failures++;
        $display("FAIL patterns_byte%0d: got %h expected %h", i, echo_q[i],
                 {1'b1, pats[i], 1'b0});
      end
    end
    step(20);
  endtask

  task automatic test_mid_reset;
    echo_q.delete();
    fall_q.delete();
    fork
      send_frame(8'hFF, 1'b1);
      begin
        step(70);
        checks++;
        if (state[1:0] !== 2'd2) begin
          failures++;
          $display("FAIL midrst_busy: got %0d expected 2", state[1:0]);
        end
        reset = 1'b1;
        step(1);
        checks++;
        if (state !== 4'h0 || tx !== 1'b1) begin
          failures++;
          $display("FAIL midrst_clear: got state=%h tx=%b expected 0/1", state, tx);
        end
        reset = 1'b0;
      end
    join
    step(300);
    checks++;
    if (echo_q.size() != 0 || state !== 4'h0) begin
      failures++;
      $display("FAIL midrst_no_echo: got echoes=%0d state=%h expected 0/0",
               echo_q.size(), state);
    end
    send_frame(8'h55, 1'b1);
    wait_echoes(1, 400);
    checks++;
    if (echo_q[0] !== {1'b1, 8'h55, 1'b0}) begin
      failures++;
      $display("FAIL midrst_next: got %h expected %h", echo_q[0], {1'b1, 8'h55, 1'b0});
    end
    step(20);
  endtask

  task automatic test_back_to_back;
    int base;
    echo_q.delete();
    fall_q.delete();
    base = cyc;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    wait_echoes(2, 800);
    checks++;
    if (echo_q.size() != 2) begin
      failures++;
      $display("FAIL overlap_count: got %0d expected 2", echo_q.size());
    end
    checks++;
    if (echo_q[0] !== {1'b1, 8'hA5, 1'b0} || echo_q[1] !== {1'b1, 8'h3C, 1'b0}) begin
      failures++;
      $display("FAIL overlap_bytes: got %h %h expected %h %h", echo_q[0], echo_q[1],
               {1'b1, 8'hA5, 1'b0}, {1'b1, 8'h3C, 1'b0});
    end
    checks++;
    if (fall_q[0] != base + 154) begin
      failures++;
      $display("FAIL overlap_first_start: got %0d expected 154", fall_q[0] - base);
    end
    checks++;
    if (fall_q[1] - fall_q[0] != 161) begin
      failures++;
      $display("FAIL overlap_second_start: got %0d expected 161", fall_q[1] - fall_q[0]);
    end
    step(20);
  endtask

  // Stop bit held low: byte still delivered, and the low line then looks like
  // a new start bit, yielding a second frame of all ones once the line rises.
  task automatic test_bad_stop;
    echo_q.delete();
    fall_q.delete();
    fork
      send_frame(8'hC3, 1'b0);
      begin
        step(152);
        checks++;
        if (state[1:0] !== 2'd3) begin
          failures++;
          $display("FAIL badstop_hold: got %0d expected 3", state[1:0]);
        end
        step(1);
        checks++;
        if (state[1:0] !== 2'd0) begin
          failures++;
          $display("FAIL badstop_idle: got %0d expected 0", state[1:0]);
        end
        step(1);
        checks++;
        if (state[1:0] !== 2'd1) begin
          failures++;
          $display("FAIL badstop_restart: got %0d expected 1", state[1:0]);
        end
      end
    join
    wait_echoes(2, 800);
    checks++;
    if (echo_q[0] !== {1'b1, 8'hC3, 1'b0}) begin
      failures++;
      $display("FAIL badstop_byte: got %h expected %h", echo_q[0], {1'b1, 8'hC3, 1'b0});
    end
    checks++;
    if (echo_q[1] !== {1'b1, 8'hFF, 1'b0}) begin
      failures++;
      $display("FAIL badstop_false_start: got %h expected %h", echo_q[1],
               {1'b1, 8'hFF, 1'b0});
    end
    step(20);
  endtask

  initial begin
    reset = 1'b1;
    i_rx  = 1'b1;
    test_reset();
    test_single();
    test_patterns();
    test_mid_reset();
    test_back_to_back();
    test_bad_stop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
